// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
// Holds the access-type encodings, FSM state encodings, bus widths and
// the small address/lane helper functions used by mem_lsu and load_align.
package mem_lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;
  localparam int REG_W  = 5;

  typedef enum logic [3:0] {
    MEMOP_NOP = 4'd0,
    MEMOP_LB  = 4'd1,
    MEMOP_LBU = 4'd2,
    MEMOP_LH  = 4'd3,
    MEMOP_LHU = 4'd4,
    MEMOP_LW  = 4'd5,
    MEMOP_SB  = 4'd6,
    MEMOP_SH  = 4'd7,
    MEMOP_SW  = 4'd8
  } memop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unknown encodings behave as NOP.
  function automatic logic is_access(input memop_t op);
    is_access = (op >= MEMOP_LB) && (op <= MEMOP_SW);
  endfunction

  function automatic logic is_store(input memop_t op);
    is_store = (op == MEMOP_SB) || (op == MEMOP_SH) || (op == MEMOP_SW);
  endfunction

  function automatic logic is_misaligned(input memop_t op, input logic [1:0] lo);
    case (op)
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: is_misaligned = lo[0];
      MEMOP_LW, MEMOP_SW:            is_misaligned = (lo != 2'b00);
      default:                       is_misaligned = 1'b0;
    endcase
  endfunction

  // Little-endian byte-lane enables.
  function automatic logic [SEL_W-1:0] lane_sel(input memop_t op, input logic [1:0] lo);
    case (op)
      MEMOP_LB, MEMOP_LBU, MEMOP_SB: lane_sel = 4'b0001 << lo;
      MEMOP_LH, MEMOP_LHU, MEMOP_SH: lane_sel = lo[1] ? 4'b1100 : 4'b0011;
      MEMOP_LW, MEMOP_SW:            lane_sel = 4'b1111;
      default:                       lane_sel = 4'b0000;
    endcase
  endfunction

  // Store data replicated across all lanes; the byte enables pick the live one.
  function automatic logic [DATA_W-1:0] store_data(input memop_t op, input logic [DATA_W-1:0] d);
    case (op)
      MEMOP_SB: store_data = {4{d[7:0]}};
      MEMOP_SH: store_data = {2{d[15:0]}};
      MEMOP_SW: store_data = d;
      default:  store_data = '0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// load_align: combinational lane extraction and sign/zero extension of
// a read word.
// Ports: memop (access type), addr_lo (byte offset), rdata (bus word),
//        result (register-ready load value).
module load_align
  import mem_lsu_pkg::*;
(
  input  logic [3:0]        memop,
  input  logic [1:0]        addr_lo,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (memop_t'(memop))
      MEMOP_LB:  result = {{24{byte_v[7]}}, byte_v};
      MEMOP_LBU: result = {24'd0, byte_v};
      MEMOP_LH:  result = {{16{half_v[15]}}, half_v};
      MEMOP_LHU: result = {16'd0, half_v};
      MEMOP_LW:  result = rdata;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit with an IDLE/WAIT/DONE handshake FSM.
// Ports: clk, rst (sync, active-low), stall[5:0] (bit 4 = mem stage held);
//        ex_* writeback fields and memory op in; mem_* fields out to mem_wb;
//        stallreq_mem holds stages 0-4 while an access is outstanding;
//        addr_err pulses for a suppressed misaligned access;
//        dbus_* request/response data-bus interface.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              ex_we,
  input  logic [REG_W-1:0]  ex_waddr,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] ex_hi,
  input  logic [DATA_W-1:0] ex_lo,
  input  logic              ex_whilo,
  input  logic [3:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_memaddr,
  input  logic [DATA_W-1:0] ex_storedata,
  output logic              mem_we,
  output logic [REG_W-1:0]  mem_waddr,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] mem_hi,
  output logic [DATA_W-1:0] mem_lo,
  output logic              mem_whilo,
  output logic              stallreq_mem,
  output logic              addr_err,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [SEL_W-1:0]  dbus_sel,
  output logic [DATA_W-1:0] dbus_wdata,
  input  logic              dbus_ack,
  input  logic [DATA_W-1:0] dbus_rdata
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  // Request captured at issue so the bus stays stable through WAIT and the
  // load alignment in DONE does not depend on ex_* staying put.
  memop_t              req_op_q, req_op_d;
  logic [1:0]          req_lo_q, req_lo_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [SEL_W-1:0]    req_sel_q, req_sel_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;

  memop_t              op;
  logic                misal;
  logic                issue;
  logic [DATA_W-1:0]   load_result;
  logic                unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  assign op    = memop_t'(ex_memop);
  assign misal = is_misaligned(op, ex_memaddr[1:0]);
  assign issue = (state_q == ST_IDLE) && is_access(op) && !misal;

  load_align u_load_align (
    .memop   (req_op_q),
    .addr_lo (req_lo_q),
    .rdata   (rdata_q),
    .result  (load_result)
  );

  // Next-state and capture logic
  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    req_op_d    = req_op_q;
    req_lo_d    = req_lo_q;
    req_addr_d  = req_addr_q;
    req_sel_d   = req_sel_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          req_op_d    = op;
          req_lo_d    = ex_memaddr[1:0];
          req_addr_d  = {ex_memaddr[ADDR_W-1:2], 2'b00};
          req_sel_d   = lane_sel(op, ex_memaddr[1:0]);
          req_wdata_d = store_data(op, ex_storedata);
          if (dbus_ack) begin
            rdata_d = dbus_rdata;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dbus_ack) begin
          rdata_d = dbus_rdata;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!stall[4]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    req_op_q    <= req_op_d;
    req_lo_q    <= req_lo_d;
    req_addr_q  <= req_addr_d;
    req_sel_q   <= req_sel_d;
    req_wdata_q <= req_wdata_d;
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_result   = '0;
    mem_hi       = '0;
    mem_lo       = '0;
    mem_whilo    = 1'b0;
    stallreq_mem = 1'b0;
    addr_err     = 1'b0;
    dbus_req     = 1'b0;
    dbus_we      = 1'b0;
    dbus_addr    = '0;
    dbus_sel     = '0;
    dbus_wdata   = '0;
    if (rst) begin
      mem_we     = ex_we;
      mem_waddr  = ex_waddr;
      mem_result = ex_result;
      mem_hi     = ex_hi;
      mem_lo     = ex_lo;
      mem_whilo  = ex_whilo;
      case (state_q)
        ST_IDLE: begin
          if (issue) begin
            // Bubble toward mem_wb until the access completes.
            mem_we       = 1'b0;
            stallreq_mem = 1'b1;
            dbus_req     = 1'b1;
            dbus_we      = is_store(op);
            dbus_addr    = {ex_memaddr[ADDR_W-1:2], 2'b00};
            dbus_sel     = lane_sel(op, ex_memaddr[1:0]);
            dbus_wdata   = store_data(op, ex_storedata);
          end else if (is_access(op)) begin
            mem_we    = 1'b0;
            mem_whilo = 1'b0;
            addr_err  = 1'b1;
          end
        end
        ST_WAIT: begin
          mem_we       = 1'b0;
          stallreq_mem = 1'b1;
          dbus_req     = 1'b1;
          dbus_we      = is_store(req_op_q);
          dbus_addr    = req_addr_q;
          dbus_sel     = req_sel_q;
          dbus_wdata   = req_wdata_q;
        end
        ST_DONE: begin
          if (is_store(req_op_q)) begin
            mem_we = 1'b0;
          end else begin
            mem_result = load_result;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
